// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture slice: RGB444 field layout,
// capture FSM encoding and default frame geometry.
package cam_capture_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT_VS = 3'd2,
    ACTIVE  = 3'd3,
    DONE    = 3'd4
  } cap_state_t;

  function automatic logic [11:0] pack_rgb(input logic [3:0] r,
                                           input logic [3:0] g,
                                           input logic [3:0] b);
    logic [11:0] p;
    p = '0;
    p[R_LSB +: 4] = r;
    p[G_LSB +: 4] = g;
    p[B_LSB +: 4] = b;
    return p;
  endfunction

endpackage

// File: rtl/cam_capture_byte_pair.sv
// Pairs consecutive href bytes into one RGB444 pixel; the strobe is
// combinational and marks the byte that completes a pixel.
module cam_byte_pair
  import cam_capture_pkg::*;
#(
  parameter bit GR_FIRST = 1'b0
) (
  input  logic        pclk,
  input  logic        rstb,
  input  logic        href,
  input  logic [7:0]  in_data,
  output logic        pair_valid,
  output logic [11:0] pair_pixel
);

  logic       phase;
  logic [7:0] byte_latch;
  logic [7:0] gr_byte;
  logic [7:0] b_byte;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      phase      <= 1'b0;
      byte_latch <= '0;
    end else begin
      phase <= href ? ~phase : 1'b0;
      if (href && !phase) byte_latch <= in_data;
    end
  end

  // NOTE: every always_comb output is given a value on every path, so no
  // latch can be inferred.
  always_comb begin
    gr_byte    = GR_FIRST ? byte_latch : in_data;
    b_byte     = GR_FIRST ? in_data    : byte_latch;
    pair_valid = href & phase;
    pair_pixel = pack_rgb(gr_byte[3:0], gr_byte[7:4], b_byte[3:0]);
  end

endmodule

// File: rtl/cam_capture.sv
// One-frame-per-request camera capture: frame sync FSM, pixel/line counters,
// FIFO push with frame/line markers, sticky overflow and geometry errors.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter bit GR_FIRST = 1'b0
) (
  input  logic        pclk,
  input  logic        rstb,
  input  logic        c_vsync,
  input  logic        href,
  input  logic [7:0]  in_data,
  input  logic        cap_start,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        ovf_err,
  output logic        len_err,
  output logic        pix_valid,
  output logic [11:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  input  logic        fifo_full
);

  localparam logic [10:0] LINE_BYTES = 11'(2 * WIDTH);
  localparam logic [10:0] BYTE_SAT   = 11'h7FF;
  localparam logic [9:0]  X_END      = 10'(WIDTH);
  localparam logic [9:0]  X_LAST     = 10'(WIDTH - 1);
  localparam logic [9:0]  Y_LAST     = 10'(HEIGHT - 1);

  cap_state_t  state;
  cap_state_t  state_nxt;
  logic        vs_d;
  logic        href_d;
  logic        vs_rise;
  logic        vs_fall;
  logic        line_end;
  logic [9:0]  x_cnt;
  logic [9:0]  y_cnt;
  logic [10:0] byte_cnt;
  logic        sof_pending;
  logic        pair_valid;
  logic [11:0] pair_pixel;

  cam_byte_pair #(.GR_FIRST(GR_FIRST)) u_pair (
    .pclk       (pclk),
    .rstb       (rstb),
    .href       (href),
    .in_data    (in_data),
    .pair_valid (pair_valid),
    .pair_pixel (pair_pixel)
  );

  assign vs_rise  = c_vsync & ~vs_d;
  assign vs_fall  = ~c_vsync & vs_d;
  assign line_end = href_d & ~href;

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_start) state_nxt = ARM;
      ARM:     if (vs_rise)   state_nxt = WAIT_VS;
      WAIT_VS: if (vs_fall)   state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise || (line_end && y_cnt == Y_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_busy = 1'b0;
    cap_done = 1'b0;
    case (state)
      ARM, WAIT_VS, ACTIVE: cap_busy = 1'b1;
      DONE:                 cap_done = 1'b1;
      default:              ;
    endcase
  end

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      vs_d        <= 1'b0;
      href_d      <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      byte_cnt    <= '0;
      sof_pending <= 1'b0;
      ovf_err     <= 1'b0;
      len_err     <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
    end else begin
      vs_d      <= c_vsync;
      href_d    <= href;
      pix_valid <= 1'b0;
      if (pix_valid && fifo_full) ovf_err <= 1'b1;

      case (state)
        IDLE: if (cap_start) begin
          ovf_err <= 1'b0;
          len_err <= 1'b0;
        end
        WAIT_VS: if (vs_fall) begin
          x_cnt       <= '0;
          y_cnt       <= '0;
          byte_cnt    <= '0;
          sof_pending <= 1'b1;
        end
        ACTIVE: begin
          if (href && byte_cnt != BYTE_SAT) byte_cnt <= byte_cnt + 11'd1;
          // Pixels past the line width are dropped but counted as an error.
          if (pair_valid) begin
            if (x_cnt < X_END) begin
              pix_valid   <= 1'b1;
              pix_data    <= pair_pixel;
              pix_sof     <= sof_pending;
              pix_eol     <= (x_cnt == X_LAST);
              sof_pending <= 1'b0;
              x_cnt       <= x_cnt + 10'd1;
            end else begin
              len_err <= 1'b1;
            end
          end
          if (line_end) begin
            if (byte_cnt != LINE_BYTES) len_err <= 1'b1;
            y_cnt    <= y_cnt + 10'd1;
            x_cnt    <= '0;
            byte_cnt <= '0;
          end
          if (vs_rise) len_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 16x8 frame, with a second
// instance using the swapped byte order.
module tb_cam_capture;
  import cam_capture_pkg::*;

  localparam int W = 16;
  localparam int H = 8;

  logic        pclk = 1'b0;
  logic        rstb = 1'b0;
  logic        c_vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        cap_start = 1'b0;
  logic        fifo_full = 1'b0;

  logic        cap_busy, cap_done, ovf_err, len_err, pix_valid, pix_sof, pix_eol;
  logic [11:0] pix_data;
  logic        cap_busy_g, cap_done_g, ovf_err_g, len_err_g, pix_valid_g, pix_sof_g, pix_eol_g;
  logic [11:0] pix_data_g;

  int checks = 0;
  int errors = 0;
  int pix_cnt = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0;
  int mx = 0, my = 0;
  bit chk_data = 1'b0;
  int full_line = -1, rst_line = -1, eol_line = -1, bad_line = -1;

  cam_capture #(.WIDTH(W), .HEIGHT(H), .GR_FIRST(1'b0)) u_dut (
    .pclk(pclk), .rstb(rstb), .c_vsync(c_vsync), .href(href), .in_data(in_data),
    .cap_start(cap_start), .cap_busy(cap_busy), .cap_done(cap_done),
    .ovf_err(ovf_err), .len_err(len_err), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .fifo_full(fifo_full)
  );

  cam_capture #(.WIDTH(W), .HEIGHT(H), .GR_FIRST(1'b1)) u_dut_g (
    .pclk(pclk), .rstb(rstb), .c_vsync(c_vsync), .href(href), .in_data(in_data),
    .cap_start(cap_start), .cap_busy(cap_busy_g), .cap_done(cap_done_g),
    .ovf_err(ovf_err_g), .len_err(len_err_g), .pix_valid(pix_valid_g),
    .pix_data(pix_data_g), .pix_sof(pix_sof_g), .pix_eol(pix_eol_g), .fifo_full(fifo_full)
  );

  always #5 pclk = ~pclk;

  function automatic logic [11:0] pix_fn(input int x, input int y);
    logic [3:0] r, g, b;
    r = 4'((x + 3 * y) % 16);
    g = 4'((y + 1) % 16);
    b = 4'(x % 16);
    return {r, g, b};
  endfunction

  // byte0 = {4'h0,B}, byte1 = {G,R}
  function automatic logic [7:0] gen_byte(input int x, input int y, input int ph);
    logic [11:0] p;
    p = pix_fn(x, y);
    return (ph == 1) ? {p[7:4], p[11:8]} : {4'h0, p[3:0]};
  endfunction

  always @(negedge pclk) begin
    if (rstb && pix_valid) begin
      pix_cnt++;
      if (pix_sof) begin
        sof_cnt++;
        mx = 0;
        my = 0;
      end
      if (pix_eol) eol_cnt++;
      if (chk_data) begin
        checks++;
        if (pix_data !== pix_fn(mx, my) || pix_eol !== (mx == W - 1)) begin
          errors++;
          $display("FAIL frame_pixel x=%0d y=%0d: got data %h eol %b, expected data %h eol %b",
                   mx, my, pix_data, pix_eol, pix_fn(mx, my), (mx == W - 1));
        end
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my++;
      end
    end
    if (rstb && cap_done) done_cnt++;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_counts();
    pix_cnt = 0; sof_cnt = 0; eol_cnt = 0; done_cnt = 0;
  endtask

  task automatic pulse_start();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  task automatic send_vsync();
    c_vsync = 1'b1;
    repeat (4) tick();
    c_vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_line(input int y, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      href      = 1'b1;
      in_data   = gen_byte(i / 2, y, i % 2);
      fifo_full = (y == full_line) && (i < 20);
      tick();
      if (y == eol_line && (i % 2) == 1) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_eol !== (i == 2 * W - 1)) begin
          errors++;
          $display("FAIL line_after_short byte=%0d: got valid %b eol %b, expected valid 1 eol %b",
                   i, pix_valid, pix_eol, (i == 2 * W - 1));
        end
      end
      if (y == rst_line && i == 10) begin
        rstb = 1'b0;
        #1;
        checks++;
        if ({cap_busy, cap_done, ovf_err, len_err, pix_valid, pix_sof, pix_eol, pix_data} !== 19'h0) begin
          errors++;
          $display("FAIL reset_mid_frame_outputs: got %h expected 0",
                   {cap_busy, cap_done, ovf_err, len_err, pix_valid, pix_sof, pix_eol, pix_data});
        end
        checks++;
        if (u_dut.state !== IDLE) begin
          errors++;
          $display("FAIL reset_mid_frame_state: got %0d expected %0d", u_dut.state, IDLE);
        end
        repeat (2) tick();
        rstb = 1'b1;
        clear_counts();
      end
    end
    href = 1'b0; fifo_full = 1'b0; in_data = 8'h00;
    repeat (6) tick();
  endtask

  task automatic send_frame(input int nlines);
    send_vsync();
    for (int y = 0; y < nlines; y++) send_line(y, (y == bad_line) ? 2 * W - 1 : 2 * W);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cap_busy, cap_done, ovf_err, len_err, pix_valid, pix_sof, pix_eol, pix_data} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {cap_busy, cap_done, ovf_err, len_err, pix_valid, pix_sof, pix_eol, pix_data});
    end
    checks++;
    if (u_dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", u_dut.state, IDLE);
    end
    rstb = 1'b1;
    repeat (2) tick();
    checks++;
    if (cap_busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy %b valid %b expected 0 0", cap_busy, pix_valid);
    end
  endtask

  task automatic test_full_frame();
    clear_counts();
    send_vsync();
    send_line(0, 2 * W);
    send_line(1, 2 * W);
    pulse_start();
    checks++;
    if (cap_busy !== 1'b1) begin
      errors++;
      $display("FAIL arm_busy: got %b expected 1", cap_busy);
    end
    for (int y = 2; y <= H; y++) send_line(y, 2 * W);
    checks++;
    if (pix_cnt !== 0) begin
      errors++;
      $display("FAIL no_push_before_vsync: got %0d pixels expected 0", pix_cnt);
    end
    chk_data = 1'b1;
    send_frame(H + 1);
    chk_data = 1'b0;
    checks++;
    if (pix_cnt !== W * H || sof_cnt !== 1 || eol_cnt !== H || done_cnt !== 1) begin
      errors++;
      $display("FAIL frame_counts: got pix %0d sof %0d eol %0d done %0d, expected %0d 1 %0d 1",
               pix_cnt, sof_cnt, eol_cnt, done_cnt, W * H, H);
    end
    checks++;
    if (len_err !== 1'b0 || ovf_err !== 1'b0 || cap_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_flags: got len %b ovf %b busy %b expected 0 0 0", len_err, ovf_err, cap_busy);
    end
  endtask

  task automatic test_pixel_format();
    logic [7:0] line0 [2 * W];
    for (int i = 0; i < 2 * W; i++) line0[i] = 8'h00;
    line0[0] = 8'h05; line0[1] = 8'hA3; line0[2] = 8'hA3; line0[3] = 8'h05;
    clear_counts();
    pulse_start();
    send_vsync();
    for (int i = 0; i < 2 * W; i++) begin
      href = 1'b1;
      in_data = line0[i];
      tick();
      if (i == 1) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 12'h3A5 || pix_sof !== 1'b1) begin
          errors++;
          $display("FAIL format_b_first: got valid %b data %h sof %b expected 1 3a5 1", pix_valid, pix_data, pix_sof);
        end
        checks++;
        if (pix_valid_g !== 1'b1 || pix_data_g !== 12'h503) begin
          errors++;
          $display("FAIL format_gr_first_swapped: got valid %b data %h expected 1 503", pix_valid_g, pix_data_g);
        end
      end
      if (i == 3) begin
        checks++;
        if (pix_data_g !== 12'h3A5 || pix_sof_g !== 1'b0) begin
          errors++;
          $display("FAIL format_gr_first: got data %h sof %b expected 3a5 0", pix_data_g, pix_sof_g);
        end
        checks++;
        if (pix_data !== 12'h503) begin
          errors++;
          $display("FAIL format_b_first_swapped: got %h expected 503", pix_data);
        end
      end
    end
    href = 1'b0; in_data = 8'h00;
    repeat (6) tick();
    for (int y = 1; y <= H; y++) send_line(y, 2 * W);
    checks++;
    if (pix_cnt !== W * H || done_cnt !== 1 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL format_frame: got pix %0d done %0d len %b expected %0d 1 0", pix_cnt, done_cnt, len_err, W * H);
    end
  endtask

  task automatic test_overflow();
    clear_counts();
    pulse_start();
    full_line = 5;
    send_frame(H + 1);
    full_line = -1;
    checks++;
    if (ovf_err !== 1'b1 || pix_cnt !== W * H || done_cnt !== 1 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_frame: got ovf %b pix %0d done %0d len %b expected 1 %0d 1 0",
               ovf_err, pix_cnt, done_cnt, len_err, W * H);
    end
    pulse_start();
    checks++;
    if (ovf_err !== 1'b0 || cap_busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_clear: got ovf %b busy %b expected 0 1", ovf_err, cap_busy);
    end
  endtask

  task automatic test_line_length();
    clear_counts();
    bad_line = 2;
    eol_line = 3;
    send_frame(H + 1);
    bad_line = -1;
    eol_line = -1;
    checks++;
    if (len_err !== 1'b1 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL short_line_flags: got len %b ovf %b expected 1 0", len_err, ovf_err);
    end
    checks++;
    if (pix_cnt !== W * H - 1 || eol_cnt !== H - 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL short_line_counts: got pix %0d eol %0d done %0d expected %0d %0d 1",
               pix_cnt, eol_cnt, done_cnt, W * H - 1, H - 1);
    end
  endtask

  task automatic test_early_vsync();
    clear_counts();
    pulse_start();
    send_vsync();
    for (int y = 0; y < 5; y++) send_line(y, 2 * W);
    c_vsync = 1'b1;
    tick();
    checks++;
    if (cap_done !== 1'b1 || cap_busy !== 1'b0 || len_err !== 1'b1) begin
      errors++;
      $display("FAIL early_vsync_done: got done %b busy %b len %b expected 1 0 1", cap_done, cap_busy, len_err);
    end
    tick();
    checks++;
    if (cap_done !== 1'b0 || cap_busy !== 1'b0 || u_dut.state !== IDLE) begin
      errors++;
      $display("FAIL early_vsync_idle: got done %b busy %b state %0d expected 0 0 %0d",
               cap_done, cap_busy, u_dut.state, IDLE);
    end
    repeat (2) tick();
    c_vsync = 1'b0;
    repeat (2) tick();
    checks++;
    if (pix_cnt !== 5 * W || done_cnt !== 1) begin
      errors++;
      $display("FAIL early_vsync_counts: got pix %0d done %0d expected %0d 1", pix_cnt, done_cnt, 5 * W);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    pulse_start();
    rst_line = 4;
    send_frame(H + 1);
    rst_line = -1;
    checks++;
    if (pix_cnt !== 0 || done_cnt !== 0 || cap_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_frame: got pix %0d done %0d busy %b expected 0 0 0", pix_cnt, done_cnt, cap_busy);
    end
    send_frame(H + 1);
    checks++;
    if (pix_cnt !== 0 || done_cnt !== 0 || sof_cnt !== 0) begin
      errors++;
      $display("FAIL no_start_no_push: got pix %0d done %0d sof %0d expected 0 0 0", pix_cnt, done_cnt, sof_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pixel_format();
    test_overflow();
    test_line_length();
    test_early_vsync();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
